// File: rtl/pulse_event_counter_pkg.sv
// pulse_evt_pkg: shared types and default sizing for pulse_event_counter.
//   pulse_evt_state_e : FSM state encoding {IDLE, COUNT}
//   PULSE_EVT_CNT_W   : default event counter / result width
//   PULSE_EVT_WINDOW  : default window length in clk_slow cycles
package pulse_evt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } pulse_evt_state_e;

  localparam int PULSE_EVT_CNT_W  = 8;
  localparam int PULSE_EVT_WINDOW = 16;

endpackage

// File: rtl/pulse_event_counter_if.sv
// pulse_event_counter_if: result handshake of pulse_event_counter.
//   cnt_data  : window event count (saturated)
//   cnt_ovf   : count saturated in this window
//   cnt_valid : result available
//   cnt_ready : consumer accepts the result
//   dropped   : one-cycle pulse when a window result is discarded
// Modports: master (counter side), slave (consumer side).
interface pulse_event_counter_if
  import pulse_evt_pkg::*;
#(
  parameter int CNT_W = PULSE_EVT_CNT_W
);
  logic [CNT_W-1:0] cnt_data;
  logic             cnt_ovf;
  logic             cnt_valid;
  logic             cnt_ready;
  logic             dropped;

  modport master (output cnt_data, cnt_ovf, cnt_valid, dropped, input cnt_ready);
  modport slave  (input cnt_data, cnt_ovf, cnt_valid, dropped, output cnt_ready);
endinterface

// File: rtl/pulse_event_counter_edge.sv
// pulse_evt_edge: rising-edge detector for the pulse stream.
//   clk_slow : clock
//   rst_n    : async active-low reset
//   data_in  : pulse stream
//   rise     : high for one cycle on each 0->1 transition of the input
// Optional feature macro PULSE_EVT_SYNC_EN: inserts a 2-flop synchroniser
// (reset 0) ahead of the edge detector, adding 2 cycles of latency.
module pulse_evt_edge
  import pulse_evt_pkg::*;
(
  input  logic clk_slow,
  input  logic rst_n,
  input  logic data_in,
  output logic rise
);

  logic w_din;
  logic r_data_d;

`ifdef PULSE_EVT_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], data_in};
  end

  assign w_din = r_sync[1];
`else
  assign w_din = data_in;
`endif

  // Delayed copy runs every cycle regardless of FSM state, so a level
  // already high when a window opens does not count as a new edge.
  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) r_data_d <= 1'b0;
    else        r_data_d <= w_din;
  end

  assign rise = w_din & ~r_data_d;

endmodule

// File: rtl/pulse_event_counter.sv
// pulse_event_counter: counts rising edges of data_in over fixed windows of
// WINDOW clk_slow cycles and offers each saturated count on a valid/ready
// slot. A window result arriving while the slot is still occupied (and not
// being accepted that cycle) is discarded and flagged by a dropped pulse.
//   clk_slow : clock
//   rst_n    : async active-low reset
//   enable   : run windows while high; low discards the partial window
//   data_in  : pulse stream (clk_slow-synchronous unless PULSE_EVT_SYNC_EN)
//   res      : result handshake (cnt_data, cnt_ovf, cnt_valid, cnt_ready, dropped)
// Optional feature macro PULSE_EVT_SYNC_EN (see pulse_evt_edge).
module pulse_event_counter
  import pulse_evt_pkg::*;
#(
  parameter int CNT_W  = PULSE_EVT_CNT_W,
  parameter int WINDOW = PULSE_EVT_WINDOW
)(
  input  logic                  clk_slow,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  data_in,
  pulse_event_counter_if.master res
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] LAST = WIN_W'(WINDOW - 1);

  if (CNT_W < 1 || WINDOW < 2) begin : g_param_chk
    $error("pulse_event_counter: CNT_W must be >=1 and WINDOW >=2");
  end

  pulse_evt_state_e r_state;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_evt_cnt;
  logic             r_ovf_acc;
  logic [CNT_W-1:0] r_cnt_data;
  logic             r_cnt_ovf;
  logic             r_cnt_valid;
  logic             r_dropped;

  logic             w_rise;
  logic             w_at_max;
  logic             w_last;
  logic [CNT_W-1:0] w_evt_fin;
  logic             w_ovf_fin;
  logic             w_accept;
  logic             w_win_end;

  pulse_evt_edge u_edge (
    .clk_slow (clk_slow),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .rise     (w_rise)
  );

  // Count including this cycle's edge; used both for the running count and
  // as the final value on the window's last cycle.
  assign w_at_max  = &r_evt_cnt;
  assign w_last    = (r_win_cnt == LAST);
  assign w_evt_fin = r_evt_cnt + CNT_W'(w_rise & ~w_at_max);
  assign w_ovf_fin = r_ovf_acc | (w_rise & w_at_max);
  assign w_accept  = r_cnt_valid & res.cnt_ready;
  // A window only completes if enable is still high on its last cycle.
  assign w_win_end = (r_state == COUNT) & enable & w_last;

  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_win_cnt   <= '0;
      r_evt_cnt   <= '0;
      r_ovf_acc   <= 1'b0;
      r_cnt_data  <= '0;
      r_cnt_ovf   <= 1'b0;
      r_cnt_valid <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_dropped <= 1'b0;

      // Output slot: runs independently of the FSM so a pending result
      // survives an enable drop. Load wins over accept, giving back-to-back
      // results with no bubble.
      if (w_win_end) begin
        if (!r_cnt_valid || w_accept) begin
          r_cnt_data  <= w_evt_fin;
          r_cnt_ovf   <= w_ovf_fin;
          r_cnt_valid <= 1'b1;
        end else begin
          r_dropped   <= 1'b1;
        end
      end else if (w_accept) begin
        r_cnt_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state   <= COUNT;
            r_win_cnt <= '0;
            r_evt_cnt <= '0;
            r_ovf_acc <= 1'b0;
          end
        end
        COUNT: begin
          if (!enable) begin
            r_state   <= IDLE;
            r_win_cnt <= '0;
            r_evt_cnt <= '0;
            r_ovf_acc <= 1'b0;
          end else if (w_last) begin
            r_win_cnt <= '0;
            r_evt_cnt <= '0;
            r_ovf_acc <= 1'b0;
          end else begin
            r_win_cnt <= r_win_cnt + WIN_W'(1);
            r_evt_cnt <= w_evt_fin;
            r_ovf_acc <= w_ovf_fin;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res.cnt_data  = r_cnt_data;
  assign res.cnt_ovf   = r_cnt_ovf;
  assign res.cnt_valid = r_cnt_valid;
  assign res.dropped   = r_dropped;

endmodule

// File: tb/tb_pulse_event_counter.sv
// tb_pulse_event_counter: directed + randomized bench for pulse_event_counter
// (CNT_W=2, WINDOW=8, default build). The reference model counts rising
// edges per window as a plain integer and clips it only when reporting.
module tb_pulse_event_counter;

  localparam int CNT_W  = 2;
  localparam int WINDOW = 8;
  localparam int MAXV   = (1 << CNT_W) - 1;

  logic clk_slow = 1'b0;
  logic rst_n    = 1'b0;
  logic enable   = 1'b0;
  logic data_in  = 1'b0;

  pulse_event_counter_if #(.CNT_W(CNT_W)) bus ();

  pulse_event_counter #(.CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
    .clk_slow (clk_slow),
    .rst_n    (rst_n),
    .enable   (enable),
    .data_in  (data_in),
    .res      (bus.master)
  );

  always #5 clk_slow = ~clk_slow;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit m_prev, m_run, m_valid, m_ovf, m_drop;
  int m_pos, m_events, m_data;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_run = 0; m_valid = 0; m_ovf = 0; m_drop = 0;
    m_pos = 0; m_events = 0; m_data = 0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_edge(bit en, bit din, bit rdy);
    bit rise, acc, done;
    rise = din && !m_prev;
    acc  = m_valid && rdy;
    done = 0;
    m_prev = din;
    m_drop = 0;
    if (m_run) begin
      if (!en) m_run = 0;
      else begin
        m_pos++;
        m_events += int'(rise);
        if (m_pos == WINDOW) done = 1;
      end
    end else if (en) begin
      m_run = 1; m_pos = 0; m_events = 0;
    end
    if (done) begin
      if (!m_valid || acc) begin
        m_valid = 1;
        m_data  = (m_events > MAXV) ? MAXV : m_events;
        m_ovf   = (m_events > MAXV);
      end else begin
        m_drop = 1;
      end
      m_pos = 0; m_events = 0;
    end else if (acc) begin
      m_valid = 0;
    end
  endtask

  // Called at a negedge; drives inputs, clocks once, checks at next negedge.
  task automatic step(bit en, bit din, bit rdy);
    enable = en; data_in = din; bus.cnt_ready = rdy;
    @(posedge clk_slow);
    model_edge(en, din, rdy);
    @(negedge clk_slow);
    chk("valid",   32'(bus.cnt_valid), 32'(m_valid));
    chk("data",    32'(bus.cnt_data),  32'(m_data));
    chk("ovf",     32'(bus.cnt_ovf),   32'(m_ovf));
    chk("dropped", 32'(bus.dropped),   32'(m_drop));
  endtask

  // One full window with enable high; pat[0] is the first window cycle.
  task automatic win(logic [7:0] pat, bit rdy);
    for (int i = 0; i < WINDOW; i++) step(1'b1, pat[i], rdy);
  endtask

  initial begin
    model_reset();
    bus.cnt_ready = 1'b0;

    // reset held: toggling inputs must not move outputs
    repeat (4) begin
      @(negedge clk_slow);
      enable = 1'($urandom_range(0, 1));
      data_in = 1'($urandom_range(0, 1));
      bus.cnt_ready = 1'($urandom_range(0, 1));
      @(posedge clk_slow);
      #1;
      chk("rst_valid", 32'(bus.cnt_valid), 32'd0);
      chk("rst_data",  32'(bus.cnt_data),  32'd0);
      chk("rst_ovf",   32'(bus.cnt_ovf),   32'd0);
      chk("rst_drop",  32'(bus.dropped),   32'd0);
    end
    @(negedge clk_slow);
    enable = 0; data_in = 0; bus.cnt_ready = 0;
    rst_n = 1'b1;

    // idle with enable low
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
      chk("idle_valid", 32'(bus.cnt_valid), 32'd0);
    end
    step(1'b0, 1'b0, 1'b1);

    // three single-cycle pulses -> 3, no overflow, valid at t+9 for one cycle
    step(1'b1, 1'b0, 1'b1);
    win(8'b0001_0101, 1'b1);
    chk("p3_valid", 32'(bus.cnt_valid), 32'd1);
    chk("p3_data",  32'(bus.cnt_data),  32'd3);
    chk("p3_ovf",   32'(bus.cnt_ovf),   32'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("p3_once", 32'(bus.cnt_valid), 32'd0);

    // level rises once and stays high for 3 windows -> 1, 0, 0
    step(1'b1, 1'b0, 1'b1);
    win(8'hFF, 1'b1);
    chk("hold_w1", 32'(bus.cnt_data), 32'd1);
    win(8'hFF, 1'b1);
    chk("hold_w2", 32'(bus.cnt_data), 32'd0);
    chk("hold_v2", 32'(bus.cnt_valid), 32'd1);
    win(8'hFF, 1'b1);
    chk("hold_w3", 32'(bus.cnt_data), 32'd0);
    step(1'b0, 1'b0, 1'b1);

    // four pulses -> saturates at 3 with overflow
    step(1'b1, 1'b0, 1'b1);
    win(8'b0101_0101, 1'b1);
    chk("sat_data", 32'(bus.cnt_data), 32'd3);
    chk("sat_ovf",  32'(bus.cnt_ovf),  32'd1);
    step(1'b0, 1'b0, 1'b1);

    // consumer stalled across two windows (2 then 1)
    step(1'b1, 1'b0, 1'b0);
    win(8'b0000_0101, 1'b0);
    chk("bp_data1", 32'(bus.cnt_data), 32'd2);
    chk("bp_drop1", 32'(bus.dropped),  32'd0);
    win(8'b0000_0001, 1'b0);
    chk("bp_drop2", 32'(bus.dropped),  32'd1);
    chk("bp_hold",  32'(bus.cnt_data), 32'd2);
    chk("bp_valid", 32'(bus.cnt_valid), 32'd1);
    win(8'b0000_0100, 1'b1);
    chk("bp_next",  32'(bus.cnt_data), 32'd1);
    chk("bp_nv",    32'(bus.cnt_valid), 32'd1);
    step(1'b0, 1'b0, 1'b1);

    // enable drops mid-window -> partial window discarded
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'(i % 2 == 0), 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1);
      chk("abort_valid", 32'(bus.cnt_valid), 32'd0);
    end

    // reset while a result is pending clears it immediately
    step(1'b1, 1'b0, 1'b0);
    win(8'b0000_0001, 1'b0);
    chk("pre_rst_valid", 32'(bus.cnt_valid), 32'd1);
    enable = 0; data_in = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.cnt_valid), 32'd0);
    chk("mid_rst_data",  32'(bus.cnt_data),  32'd0);
    model_reset();
    @(negedge clk_slow);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
